wb_host_master: RTL

//  Wishbone classic single-cycle master (initiator) that drives the enclave's wbs_* slave port.

---
 rtl/wb_host_master.sv | 119 +++++++++++
 1 files changed

// File: rtl/wb_host_master.sv
// Wishbone classic single-cycle master: one command in, one bus transfer, one response out.
// A bus timeout converts a missing slave ack into an error response.
module wb_host_master #(
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_DATA_WIDTH = 32,
  parameter int TIMEOUT       = 255,
  parameter int TO_WIDTH      = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  // Command and response channels both use strict valid/ready: a beat transfers on
  // the rising edge where valid & ready are both high. Valid never depends on ready.
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_we,
  input  logic [WB_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [WB_DATA_WIDTH-1:0]   cmd_data,
  input  logic [WB_DATA_WIDTH/8-1:0] cmd_sel,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [WB_DATA_WIDTH-1:0]   rsp_data,
  output logic                       rsp_err,
  output logic                       busy,
  output logic [1:0]                 dbg_state,
  output logic                       wbm_cyc_o,
  output logic                       wbm_stb_o,
  output logic                       wbm_we_o,
  output logic [WB_DATA_WIDTH/8-1:0] wbm_sel_o,
  output logic [WB_ADDR_WIDTH-1:0]   wbm_adr_o,
  output logic [WB_DATA_WIDTH-1:0]   wbm_dat_o,
  input  logic                       wbm_ack_i,
  input  logic [WB_DATA_WIDTH-1:0]   wbm_dat_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RSP  = 2'd2
  } state_t;

  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT - 1);

  state_t              state;
  logic [TO_WIDTH-1:0] to_cnt;

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      to_cnt    <= '0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            state     <= BUS;
            to_cnt    <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= cmd_we;
            wbm_sel_o <= cmd_sel;
            wbm_adr_o <= cmd_addr;
            wbm_dat_o <= cmd_data;
          end
        end
        BUS: begin
          // Ack is tested first so an ack on the final allowed cycle still succeeds.
          if (wbm_ack_i) begin
            state     <= RSP;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_data  <= wbm_we_o ? '0 : wbm_dat_i;
          end else if (to_cnt == TO_LAST) begin
            state     <= RSP;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_data  <= '0;
          end else begin
            to_cnt <= to_cnt + TO_WIDTH'(1);
          end
        end
        RSP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          wbm_cyc_o <= 1'b0;
          wbm_stb_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
